// File: rtl/ddr3_rw_test.sv
// rtl/ddr3_rw_test.sv - DDR3 write/read pattern tester: fills TEST_LEN words, reads them back and compares
module ddr3_rw_test #(
    parameter logic [15:0] TEST_LEN = 16'd1024,
    parameter logic [15:0] WAIT_CYC = 16'd2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ddr3_init_done,
    output logic        wd_en,
    output logic [15:0] wd_data,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        error_flag,
    output logic [15:0] err_cnt,
    output logic [7:0]  pass_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT_WAIT = 3'd1,
        WRITE     = 3'd2,
        GAP       = 3'd3,
        READ      = 3'd4,
        CHECK     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  pass_cnt_q, pass_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        error_flag_q, error_flag_d;
    logic        wd_en_q, wd_en_d;
    logic [15:0] wd_data_q, wd_data_d;
    logic        rd_en_q, rd_en_d;
    logic        cmp_vld_q, cmp_vld_d;
    logic [15:0] exp_q, exp_d;

    logic        wait_done;
    logic        last_idx;
    logic        abort;
    logic        mismatch;

    // Wait interval ends on its last cycle; a zero WAIT_CYC behaves like one cycle.
    assign wait_done = (({1'b0, cnt_q} + 17'd1) >= {1'b0, WAIT_CYC});
    assign last_idx  = (idx_q == (TEST_LEN - 16'd1));
    // Losing calibration anywhere outside IDLE throws the tester back to IDLE.
    assign abort     = (state_q != IDLE) && !ddr3_init_done;

    // Next state, word index, phase counter and pass counter.
    always_comb begin
        state_d    = state_q;
        idx_d      = 16'd0;
        cnt_d      = 16'd0;
        pass_cnt_d = pass_cnt_q;
        case (state_q)
            IDLE: begin
                if (ddr3_init_done) begin
                    state_d = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (wait_done) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WRITE: begin
                if (last_idx) begin
                    state_d = GAP;
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            GAP: begin
                if (wait_done) begin
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            READ: begin
                if (last_idx) begin
                    state_d = CHECK;
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            CHECK: begin
                pass_cnt_d = pass_cnt_q + 8'd1;
                state_d    = WRITE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d    = IDLE;
            idx_d      = 16'd0;
            cnt_d      = 16'd0;
            pass_cnt_d = pass_cnt_q;
        end
    end

    // Strobes and write word are registered from the next state so they line up with the phase.
    always_comb begin
        wd_en_d   = (state_d == WRITE);
        rd_en_d   = (state_d == READ);
        wd_data_d = 16'd0;
        if (wd_en_d) begin
            wd_data_d = idx_d + {pass_cnt_d, 8'h00};
        end
    end

    // Expected word follows the read index one cycle later, when rd_data is valid.
    always_comb begin
        cmp_vld_d    = (state_q == READ) && ddr3_init_done;
        exp_d        = 16'd0;
        if (state_q == READ) begin
            exp_d = idx_q + {pass_cnt_q, 8'h00};
        end
        mismatch     = cmp_vld_q && (rd_data != exp_q);
        error_flag_d = error_flag_q | mismatch;
        err_cnt_d    = err_cnt_q;
        if (mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // All state, counters, strobes and the compare pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 16'd0;
            cnt_q        <= 16'd0;
            pass_cnt_q   <= 8'd0;
            err_cnt_q    <= 16'd0;
            error_flag_q <= 1'b0;
            wd_en_q      <= 1'b0;
            wd_data_q    <= 16'd0;
            rd_en_q      <= 1'b0;
            cmp_vld_q    <= 1'b0;
            exp_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            err_cnt_q    <= err_cnt_d;
            error_flag_q <= error_flag_d;
            wd_en_q      <= wd_en_d;
            wd_data_q    <= wd_data_d;
            rd_en_q      <= rd_en_d;
            cmp_vld_q    <= cmp_vld_d;
            exp_q        <= exp_d;
        end
    end

    assign wd_en      = wd_en_q;
    assign wd_data    = wd_data_q;
    assign rd_en      = rd_en_q;
    assign error_flag = error_flag_q;
    assign err_cnt    = err_cnt_q;
    assign pass_cnt   = pass_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/ddr3_rw_test.md
DDR3_RW_TEST -- requirements
Module: ddr3_rw_test

Interface
REQ-001 SHALL have parameter TEST_LEN, default 16'd1024, giving the number of 16-bit words written and read per pass (legal range 1..65535).
REQ-002 SHALL have parameter WAIT_CYC, default 16'd2000, giving the idle cycles after init done and between the write and read phases.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; shared with wd_clk/rd_clk of the controller top.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port ddr3_init_done, input, 1 bit: DDR3 calibrated and controller ready.
REQ-006 SHALL have port wd_en, output, 1 bit: write-FIFO push strobe.
REQ-007 SHALL have port wd_data, output, 16 bits: write word.
REQ-008 SHALL have port rd_en, output, 1 bit: read-FIFO pop strobe.
REQ-009 SHALL have port rd_data, input, 16 bits: read word, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have port error_flag, output, 1 bit: sticky mismatch indicator.
REQ-011 SHALL have port err_cnt, output, 16 bits: mismatch count.
REQ-012 SHALL have port pass_cnt, output, 8 bits: completed write/read passes.
REQ-013 SHALL have port busy, output, 1 bit: high in any state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, INIT_WAIT, WRITE, GAP, READ, CHECK.
REQ-015 IDLE SHALL go to INIT_WAIT when ddr3_init_done=1.
REQ-016 INIT_WAIT SHALL count WAIT_CYC cycles, then enter WRITE.
REQ-017 WRITE SHALL assert wd_en for exactly TEST_LEN consecutive cycles, with word index i = 0..TEST_LEN-1, then enter GAP.
REQ-018 wd_data SHALL equal (i + {pass_cnt,8'h00}) mod 2^16, registered alongside wd_en.
REQ-019 GAP SHALL count WAIT_CYC cycles with no strobes, then enter READ.
REQ-020 READ SHALL assert rd_en for exactly TEST_LEN consecutive cycles, then enter CHECK.
REQ-021 The expected word SHALL be computed with the same formula as wd_data, using the read index, and delayed 1 cycle to align with rd_data.
REQ-022 A compare SHALL occur in each cycle after an rd_en=1 cycle, including the first CHECK cycle.
REQ-023 CHECK SHALL last 1 cycle, then increment pass_cnt (wrapping 255->0) and return to WRITE.
REQ-024 On a mismatch, error_flag SHALL set and stay set until reset.
REQ-025 On a mismatch, err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-026 wd_en and rd_en SHALL never be high in the same cycle.
REQ-027 Each strobe SHALL be high only in its own phase.
REQ-028 If ddr3_init_done=0 in any state other than IDLE, the FSM SHALL enter IDLE next cycle and deassert wd_en/rd_en.
REQ-029 That abort SHALL drop any pending compare and SHALL clear the word index and phase counters.
REQ-030 The abort SHALL preserve error_flag, err_cnt and pass_cnt.
REQ-031 The word index SHALL be 16 bits and SHALL reset to 0 on entry to WRITE and on entry to READ.

Reset
REQ-032 While rst_n=0, all outputs SHALL be 0 and the FSM SHALL be in IDLE.
REQ-033 While rst_n=0, all counters and the compare pipeline SHALL be 0.
REQ-034 Reset SHALL take effect asynchronously mid-phase.
REQ-035 After reset release, no strobe SHALL be issued before ddr3_init_done=1 and the WAIT_CYC interval has elapsed.

Verification
REQ-036 Clean pass, TEST_LEN=8, WAIT_CYC=4, ideal memory model returning written data -> wd_data 0..7 over 8 cycles; 4 idle cycles; 8 rd_en cycles; error_flag=0; pass_cnt=1; second pass writes 0x0100..0x0107.
REQ-037 Single-bit corruption: model flips bit 0 of word 3 -> err_cnt=1 and error_flag=1 one cycle after the 4th rd_en; both still set after the next clean pass.
REQ-038 Init gating: ddr3_init_done held 0 for 100 cycles after reset -> busy=0, no strobes; assert it -> first wd_en exactly WAIT_CYC+1 cycles later.
REQ-039 Abort: drop ddr3_init_done at the 3rd READ cycle -> rd_en=0 next cycle, FSM in IDLE, err_cnt unchanged; re-assert -> restarts at INIT_WAIT and writes word 0 of the current pass_cnt.
REQ-040 Async reset mid-WRITE (rst_n low for half a cycle) -> all outputs 0 immediately.
REQ-041 Wrap/saturation: force pass_cnt=255 -> wraps to 0 after CHECK; all-mismatch model with err_cnt preset to 16'hFFFE -> holds at 16'hFFFF.
REQ-042 Every scenario SHALL be checked for no cycle with wd_en=rd_en=1.
